// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM with bounded ownership hold.
// Reads return one cycle after issue and go to the master that issued them.
module onchip_mem_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
   localparam logic [3:0] HOLD_MAX = 4'd15;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     r_state;
   logic       r_last_owner;
   logic [3:0] r_hold_cnt;
   logic       r_rd_pend;
   logic       r_rd_owner;

   logic w_req0, w_req1;
   logic w_issue, w_sel;
   logic w_rd_sel, w_wr_sel;
   logic w_hold_ok;

   assign w_req0    = m0_read | m0_write;
   assign w_req1    = m1_read | m1_write;
   assign w_hold_ok = r_hold_cnt < HOLD_LIM;

   // Grant selection; an owner keeps the RAM until its hold budget runs out under contention.
   always_comb begin
      w_issue = 1'b0;
      w_sel   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 && w_req1) begin
               w_issue = 1'b1;
               w_sel   = ~r_last_owner;
            end else if (w_req0) begin
               w_issue = 1'b1;
               w_sel   = 1'b0;
            end else if (w_req1) begin
               w_issue = 1'b1;
               w_sel   = 1'b1;
            end
         end
         OWN0: begin
            if (w_req0 && (!w_req1 || w_hold_ok)) begin
               w_issue = 1'b1;
               w_sel   = 1'b0;
            end else if (w_req1) begin
               w_issue = 1'b1;
               w_sel   = 1'b1;
            end
         end
         OWN1: begin
            if (w_req1 && (!w_req0 || w_hold_ok)) begin
               w_issue = 1'b1;
               w_sel   = 1'b1;
            end else if (w_req0) begin
               w_issue = 1'b1;
               w_sel   = 1'b0;
            end
         end
         default: begin
            w_issue = 1'b0;
            w_sel   = 1'b0;
         end
      endcase
      if (!reset_n) begin
         w_issue = 1'b0;
      end
   end

   // Read+write together counts as a write, so it never produces read data.
   assign w_wr_sel = w_sel ? m1_write : m0_write;
   assign w_rd_sel = w_sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
         r_hold_cnt   <= 4'd0;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else begin
         r_rd_pend  <= w_issue & w_rd_sel;
         r_rd_owner <= w_sel;
         if (w_issue) begin
            r_state      <= w_sel ? OWN1 : OWN0;
            r_last_owner <= w_sel;
            if (r_state == IDLE || w_sel != r_last_owner) begin
               r_hold_cnt <= 4'd1;
            end else if (r_hold_cnt != HOLD_MAX) begin
               r_hold_cnt <= r_hold_cnt + 4'd1;
            end
         end else begin
            r_state    <= IDLE;
            r_hold_cnt <= 4'd0;
         end
      end
   end

   assign mem_address    = w_sel ? m1_address    : m0_address;
   assign mem_byteenable = w_sel ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = w_sel ? m1_writedata  : m0_writedata;
   assign mem_chipselect = w_issue;
   assign mem_write      = w_issue & w_wr_sel;

   assign m0_waitrequest = ~reset_n | (w_req0 & ~(w_issue & ~w_sel));
   assign m1_waitrequest = ~reset_n | (w_req1 & ~(w_issue &  w_sel));

   // Reset also masks a return that was already in flight.
   assign m0_readdatavalid = reset_n & r_rd_pend & ~r_rd_owner;
   assign m1_readdatavalid = reset_n & r_rd_pend &  r_rd_owner;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: driver queues expected read returns,
// a negedge monitor pops them as readdatavalid pulses appear.
module tb_onchip_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [12:0] m0_address, m1_address;
   logic [7:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [63:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [63:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [12:0] mem_address;
   logic [7:0]  mem_byteenable;
   logic        mem_chipselect, mem_write;
   logic [63:0] mem_writedata, mem_readdata;

   onchip_mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   // Synchronous RAM: byte-lane writes, q registered one cycle after a read.
   logic [63:0] ram [0:8191];
   initial begin
      for (int i = 0; i < 8192; i++) ram[i] = 64'd0;
      mem_readdata = 64'd0;
   end
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 8; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   typedef struct { bit m; logic [63:0] d; } exp_t;
   exp_t sb [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: every readdatavalid pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      exp_t e;
      if (m0_readdatavalid || m1_readdatavalid) begin
         chk("rdv_onehot", 64'(m0_readdatavalid & m1_readdatavalid), 64'd0);
         if (sb.size() == 0) begin
            chk("rdv_unexpected", 64'(m1_readdatavalid), 64'hx);
         end else begin
            e = sb.pop_front();
            chk("rdv_master", 64'(m1_readdatavalid), 64'(e.m));
            chk("rdv_data", e.m ? m1_readdata : m0_readdata, e.d);
         end
      end
   end

   logic [63:0] exp0, exp1;
   bit          g_push;
   logic        s_wait0, s_wait1, s_acc0, s_acc1, s_cs, s_wr;

   // One bus cycle: sample at negedge, queue accepted reads, return just after next posedge.
   task automatic step();
      bit p0, p1;
      logic [63:0] d0, d1;
      @(negedge clk);
      s_wait0 = m0_waitrequest;
      s_wait1 = m1_waitrequest;
      s_acc0  = (m0_read | m0_write) & ~m0_waitrequest;
      s_acc1  = (m1_read | m1_write) & ~m1_waitrequest;
      s_cs    = mem_chipselect;
      s_wr    = mem_write;
      p0 = g_push && s_acc0 && m0_read && !m0_write;
      p1 = g_push && s_acc1 && m1_read && !m1_write;
      d0 = exp0;
      d1 = exp1;
      #1;
      if (p0) sb.push_back('{m: 1'b0, d: d0});
      if (p1) sb.push_back('{m: 1'b1, d: d1});
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input bit m, input bit rd, input bit wr, input logic [12:0] a,
                        input logic [63:0] d, input logic [7:0] be, input logic [63:0] ex);
      if (m) begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be; exp1 = ex;
      end else begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be; exp0 = ex;
      end
   endtask

   // Single command from one master, held until accepted (bounded).
   task automatic cmd(input bit m, input bit rd, input bit wr, input logic [12:0] a,
                      input logic [63:0] d, input logic [7:0] be, input logic [63:0] ex);
      bit done = 1'b0;
      int n = 0;
      set_m(m, rd, wr, a, d, be, ex);
      while (!done && n < 16) begin
         step();
         done = m ? s_acc1 : s_acc0;
         n++;
      end
      chk("cmd_accept", 64'(done), 64'd1);
      set_m(m, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      g_push = 1'b1;
      reset_n = 1'b0;
      set_m(1'b0, 1'b1, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      set_m(1'b1, 1'b0, 1'b1, 13'd0, 64'd0, 8'd0, 64'd0);
      // Reset forces waitrequest and blocks RAM access.
      repeat (2) begin
         step();
         chk("rst_wait0", 64'(s_wait0), 64'd1);
         chk("rst_wait1", 64'(s_wait1), 64'd1);
         chk("rst_cs", 64'(s_cs), 64'd0);
         chk("rst_wr", 64'(s_wr), 64'd0);
      end
      set_m(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      set_m(1'b1, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      reset_n = 1'b1;
      step();
      chk("idle_wait0", 64'(s_wait0), 64'd0);
      chk("idle_wait1", 64'(s_wait1), 64'd0);

      // m0 writes, m1 reads it back.
      cmd(1'b0, 1'b0, 1'b1, 13'h0010, 64'h0123456789ABCDEF, 8'hFF, 64'd0);
      cmd(1'b1, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'h0123456789ABCDEF);
      idle(2);

      // Top address with lane masking.
      cmd(1'b0, 1'b0, 1'b1, 13'h1FFF, 64'd0, 8'hFF, 64'd0);
      cmd(1'b0, 1'b0, 1'b1, 13'h1FFF, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0);
      cmd(1'b0, 1'b1, 1'b0, 13'h1FFF, 64'd0, 8'd0, 64'h00000000FFFFFFFF);
      idle(2);

      // Read+write together is a write with no read return.
      cmd(1'b0, 1'b1, 1'b1, 13'h0005, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'd0);
      idle(2);
      cmd(1'b0, 1'b1, 1'b0, 13'h0005, 64'd0, 8'd0, 64'hDEADBEEFCAFEF00D);
      idle(2);

      // After reset, contention rotates ownership every four issues, m0 first.
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      set_m(1'b0, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'h0123456789ABCDEF);
      set_m(1'b1, 1'b1, 1'b0, 13'h1FFF, 64'd0, 8'd0, 64'h00000000FFFFFFFF);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("order_acc0", 64'(s_acc0), 64'(i < 4 || i >= 8));
         chk("order_wait1", 64'(s_wait1), 64'(i < 4 || i >= 8));
         chk("order_wait0", 64'(s_wait0), 64'(i >= 4 && i < 8));
      end
      set_m(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      set_m(1'b1, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      idle(2);

      // Alternating single reads, one per cycle.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) set_m(1'b0, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'h0123456789ABCDEF);
         else            set_m(1'b1, 1'b1, 1'b0, 13'h0005, 64'd0, 8'd0, 64'hDEADBEEFCAFEF00D);
         step();
         chk("alt_accept", 64'((i % 2 == 0) ? s_acc0 : s_acc1), 64'd1);
         set_m(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
         set_m(1'b1, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      end
      idle(2);

      // m1 read in flight when reset asserts: its return is dropped.
      g_push = 1'b0;
      cmd(1'b1, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'd0);
      g_push = 1'b1;
      reset_n = 1'b0;
      set_m(1'b0, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'h0123456789ABCDEF);
      set_m(1'b1, 1'b1, 1'b0, 13'h0010, 64'd0, 8'd0, 64'h0123456789ABCDEF);
      repeat (2) begin
         step();
         chk("rst2_wait0", 64'(s_wait0), 64'd1);
         chk("rst2_wait1", 64'(s_wait1), 64'd1);
         chk("rst2_cs", 64'(s_cs), 64'd0);
      end
      reset_n = 1'b1;
      step();
      chk("rst2_first_m0", 64'(s_acc0), 64'd1);
      chk("rst2_first_m1_wait", 64'(s_wait1), 64'd1);
      set_m(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      step();
      chk("rst2_then_m1", 64'(s_acc1), 64'd1);
      set_m(1'b1, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 64'd0);
      idle(3);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word-address width (8192 x 64-bit words).
REQ-002 SHALL have parameter DATA_W, default 64, data width; byteenable width SHALL be DATA_W/8.
REQ-003 SHALL have parameter MAX_HOLD, default 4, maximum consecutive issue cycles per owner while the other master waits (legal range 1-15).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous to clk, active-low.
REQ-006 SHALL have ports mN_address (N=0,1)  input  ADDR_W  word address from master N.
REQ-007 SHALL have ports mN_byteenable  input  DATA_W/8  write byte lanes.
REQ-008 SHALL have ports mN_read  input  1  read request.
REQ-009 SHALL have ports mN_write  input  1  write request.
REQ-010 SHALL have ports mN_writedata  input  DATA_W  write data.
REQ-011 SHALL have ports mN_waitrequest  output  1  high = command not accepted this cycle; master holds command.
REQ-012 SHALL have ports mN_readdata  output  DATA_W  read data.
REQ-013 SHALL have ports mN_readdatavalid  output  1  one-cycle pulse qualifying mN_readdata.
REQ-014 SHALL have port mem_address  output  ADDR_W  to RAM port A.
REQ-015 SHALL have port mem_byteenable  output  DATA_W/8  to RAM.
REQ-016 SHALL have port mem_chipselect  output  1  to RAM.
REQ-017 SHALL have port mem_write  output  1  to RAM (wren = chipselect & write).
REQ-018 SHALL have port mem_writedata  output  DATA_W  to RAM.
REQ-019 SHALL have port mem_readdata  input  DATA_W  RAM q, valid exactly 1 cycle after a read is issued.

Function
REQ-020 SHALL define reqN = mN_read | mN_write; a command is accepted in a cycle when reqN=1 and mN_waitrequest=0.
REQ-021 SHALL issue at most one command to the RAM per cycle; non-selected requesting master sees mN_waitrequest=1 in that cycle.
REQ-022 SHALL implement FSM states IDLE, OWN0, OWN1 plus registers last_owner (1 bit) and hold_cnt (4 bits).
REQ-023 SHALL select, in IDLE: the sole requester; if both request, the master != last_owner.
REQ-024 SHALL select, in OWNx: x if reqx=1 and (other idle or hold_cnt < MAX_HOLD); else the other master if requesting; else none.
REQ-025 SHALL on each issue set state OWNsel, last_owner=sel, hold_cnt=1 if sel changed or from IDLE, else hold_cnt+1 saturating at 15; with no issue go to IDLE, hold_cnt=0, last_owner kept.
REQ-026 SHALL drive mem_* combinationally from the selected master in the issuing cycle; mem_chipselect=0 and mem_write=0 when none selected.
REQ-027 SHALL treat mN_read=mN_write=1 as a write only; no readdatavalid results.
REQ-028 SHALL register (rd_pend, rd_owner) on each issued read and assert m<rd_owner>_readdatavalid=1 exactly one cycle later with m<rd_owner>_readdata = mem_readdata; the other master's readdatavalid=0.
REQ-029 SHALL drive mN_readdata = mem_readdata continuously (qualified only by readdatavalid).
REQ-030 SHALL allow back-to-back reads on consecutive cycles, including alternating owners, with one readdatavalid per read in issue order.
REQ-031 SHALL keep mN_waitrequest=0 when reqN=0 only if mN is selectable; otherwise waitrequest SHALL equal reqN & ~selN.

Reset
REQ-032 SHALL on clk edge with reset_n=0 set state=IDLE, last_owner=1 (m0 wins first tie), hold_cnt=0, rd_pend=0.
REQ-033 SHALL while reset_n=0 force mN_waitrequest=1, mN_readdatavalid=0, mem_chipselect=0, mem_write=0; a read issued in the cycle before reset asserts SHALL produce no readdatavalid.

Verification
REQ-034 SHALL verify: m0 write addr 0x0010 data 0x0123456789ABCDEF be 0xFF, then m1 read 0x0010 -> m1_readdatavalid one cycle after accept, m1_readdata=0x0123456789ABCDEF, m0_readdatavalid=0.
REQ-035 SHALL verify: after reset both masters read continuously -> issue order m0 x4, m1 x4, m0 x4; waiter's waitrequest=1 throughout its gap.
REQ-036 SHALL verify: m0 write be 0x0F data all-ones over 0 at 0x1FFF -> read returns 0x00000000FFFFFFFF (top address, lane masking).
REQ-037 SHALL verify: alternating single reads m0/m1 each cycle -> readdatavalid alternates m0,m1 with no gaps or swaps.
REQ-038 SHALL verify: m1 read accepted, reset_n=0 next cycle for 2 cycles -> no readdatavalid, all waitrequest=1; after release simultaneous requests grant m0 first.
REQ-039 SHALL verify: m0_read=m0_write=1 at 0x0005 -> RAM written, no m0_readdatavalid pulse.
